uart_receiver: RTL and testbench

- Serial-to-parallel UART receive stage; the counterpart that consumes the `tx_out` line of `uart_transmitter`.
- Frame format: 8N1, LSB first, line idle high.
- Samples at mid-bit using a baud counter. Presents each received byte with a one-cycle valid pulse.
- Reports stop-bit framing errors and recovers cleanly from break (line held low).

---
 rtl/uart_receiver.sv | 208 ++++++++++++++++++++
 tb/tb_uart_receiver.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// ---------------------------------------------------------------------------
// uart_receiver
//
// Serial-to-parallel UART receive stage for 8N1 frames (LSB first, line idle
// high). The asynchronous line is brought into the clk domain through two
// flops, and every decision uses that synchronized copy. A start edge is
// qualified half a bit later. Each following bit is then sampled once per bit
// period, near the middle of the bit.
//
// Optional feature (compile-time macro UART_RECEIVER_PARITY_EN):
//   Undefined (default): plain 8N1. rx_parity_error_out is tied to 0.
//   Defined: an even-parity bit follows data bit 7. A good stop bit with bad
//     parity gives a parity-error pulse instead of a valid pulse.
//
// Parameters:
//   ClocksPerBaud  clock cycles per bit period (>= 2)
//
// Ports:
//   clk                   system clock
//   rst_n                 asynchronous reset, active low
//   rx_in                 serial line, asynchronous to clk, idle high
//   rx_byte_out           last good received byte
//   rx_byte_valid_out     one-cycle pulse, rx_byte_out updated in same cycle
//   rx_framing_error_out  one-cycle pulse when the stop bit samples 0
//   rx_parity_error_out   one-cycle pulse on parity mismatch (0 unless enabled)
//   rx_busy_out           high whenever the receiver is not idle
//
// Handshake: there is no backpressure. rx_byte_valid_out is a single-cycle
// strobe and must be taken in that cycle. rx_byte_out keeps its value until
// the next good frame overwrites it.
// ---------------------------------------------------------------------------
module uart_receiver #(
  parameter int ClocksPerBaud = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_in,
  output logic [7:0] rx_byte_out,
  output logic       rx_byte_valid_out,
  output logic       rx_framing_error_out,
  output logic       rx_parity_error_out,
  output logic       rx_busy_out
);

  localparam int HalfBaud = ClocksPerBaud / 2;
  localparam int CntW     = (ClocksPerBaud > 2) ? $clog2(ClocksPerBaud) : 1;
  localparam logic [CntW-1:0] BaudLoad = CntW'(ClocksPerBaud - 1);
  localparam logic [CntW-1:0] HalfLoad = CntW'(HalfBaud - 1);

`ifdef UART_RECEIVER_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    BREAK  = 3'd4,
    PARITY = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;
`endif

  state_t          state;
  logic            rx_sync1;
  logic            rx_sync2;
  logic [7:0]      shift_reg;
  logic [2:0]      bit_cnt;
  logic [CntW-1:0] baud_cnt;
  logic            rxs;

  assign rxs         = rx_sync2;
  assign rx_busy_out = (state != IDLE);

`ifdef UART_RECEIVER_PARITY_EN
  logic parity_bit;
  logic parity_err_q;

  assign rx_parity_error_out = parity_err_q;
`else
  assign rx_parity_error_out = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                <= IDLE;
      rx_sync1             <= 1'b1;
      rx_sync2             <= 1'b1;
      shift_reg            <= '0;
      bit_cnt              <= '0;
      baud_cnt             <= '0;
      rx_byte_out          <= '0;
      rx_byte_valid_out    <= 1'b0;
      rx_framing_error_out <= 1'b0;
`ifdef UART_RECEIVER_PARITY_EN
      parity_bit           <= 1'b0;
      parity_err_q         <= 1'b0;
`endif
    end else begin
      rx_sync1             <= rx_in;
      rx_sync2             <= rx_sync1;
      // Strobes default low so that each one lasts exactly one cycle.
      rx_byte_valid_out    <= 1'b0;
      rx_framing_error_out <= 1'b0;
`ifdef UART_RECEIVER_PARITY_EN
      parity_err_q         <= 1'b0;
`endif

      case (state)
        IDLE: begin
          if (!rxs) begin
            state    <= START;
            baud_cnt <= HalfLoad;
          end
        end

        // Check the start bit again near the middle of the bit. If the line
        // is high again, the low level was only a glitch.
        START: begin
          if (baud_cnt != '0) begin
            baud_cnt <= baud_cnt - CntW'(1);
          end else if (!rxs) begin
            state    <= DATA;
            baud_cnt <= BaudLoad;
            bit_cnt  <= '0;
          end else begin
            state <= IDLE;
          end
        end

        // Shift each bit in from the MSB side. After eight shifts, bit 0 is
        // at position [0].
        DATA: begin
          if (baud_cnt != '0) begin
            baud_cnt <= baud_cnt - CntW'(1);
          end else begin
            shift_reg <= {rxs, shift_reg[7:1]};
            baud_cnt  <= BaudLoad;
            if (bit_cnt == 3'd7) begin
`ifdef UART_RECEIVER_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
        end

`ifdef UART_RECEIVER_PARITY_EN
        PARITY: begin
          if (baud_cnt != '0) begin
            baud_cnt <= baud_cnt - CntW'(1);
          end else begin
            parity_bit <= rxs;
            baud_cnt   <= BaudLoad;
            state      <= STOP;
          end
        end
`endif

        // The receiver returns to IDLE right at the mid-stop sample. It does
        // not wait for the stop bit to end, so a start bit that comes
        // straight after the stop bit is still caught.
        STOP: begin
          if (baud_cnt != '0) begin
            baud_cnt <= baud_cnt - CntW'(1);
          end else if (rxs) begin
            state <= IDLE;
`ifdef UART_RECEIVER_PARITY_EN
            // Even parity: data bits and parity bit together have an even
            // number of ones.
            if (^{shift_reg, parity_bit}) begin
              parity_err_q <= 1'b1;
            end else begin
              rx_byte_out       <= shift_reg;
              rx_byte_valid_out <= 1'b1;
            end
`else
            rx_byte_out       <= shift_reg;
            rx_byte_valid_out <= 1'b1;
`endif
          end else begin
            rx_framing_error_out <= 1'b1;
            state                <= BREAK;
          end
        end

        // A line held low (break) gives only the one framing error above.
        // Wait here until the line goes high again.
        BREAK: begin
          if (rxs) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// ---------------------------------------------------------------------------
// tb_uart_receiver
//
// Directed and randomized frames are driven onto rx_in at the bit level.
// The expected bytes, pulse counts and latencies come from the frame
// definition (start, 8 data bits LSB first, optional even parity, stop) and
// from the stated pin-to-valid latency.
// ---------------------------------------------------------------------------
module tb_uart_receiver;

  localparam int CPB  = 2;
  localparam int HALF = CPB / 2;
`ifdef UART_RECEIVER_PARITY_EN
  localparam int HAS_PAR = 1;
`else
  localparam int HAS_PAR = 0;
`endif
  // Pin edge to valid: 2 synchronizer cycles + HalfBaud + bits + 1.
  localparam int EXP_LAT = 2 + HALF + (9 + HAS_PAR) * CPB + 1;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_in;
  logic [7:0] rx_byte_out;
  logic       rx_byte_valid_out;
  logic       rx_framing_error_out;
  logic       rx_parity_error_out;
  logic       rx_busy_out;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  uart_receiver #(.ClocksPerBaud(CPB)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .rx_in                (rx_in),
    .rx_byte_out          (rx_byte_out),
    .rx_byte_valid_out    (rx_byte_valid_out),
    .rx_framing_error_out (rx_framing_error_out),
    .rx_parity_error_out  (rx_parity_error_out),
    .rx_busy_out          (rx_busy_out)
  );

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  int         obs_cyc_q[$];
  int         fe_cnt = 0;
  int         pe_cnt = 0;
  int         n_checks = 0;
  int         n_pass = 0;
  int         last_start = 0;

  // Output monitor, sampled on the falling edge away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_byte_valid_out) begin
        obs_q.push_back(rx_byte_out);
        obs_cyc_q.push_back(cyc);
      end
      if (rx_framing_error_out) fe_cnt++;
      if (rx_parity_error_out)  pe_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Compare the received bytes against the expected queue, then empty both.
  task automatic expect_bytes(input string tag);
    check({tag, "_count"}, obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      check({tag, "_byte"}, obs_q.pop_front(), exp_q.pop_front());
      void'(obs_cyc_q.pop_front());
    end
    obs_q.delete();
    obs_cyc_q.delete();
    exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  // All driver tasks start and end just after a rising edge.
  task automatic drive_bit(input logic v);
    rx_in = v;
    repeat (CPB) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    rx_in = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v, input logic par_flip);
    last_start = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    if (HAS_PAR != 0) drive_bit((^b) ^ par_flip);
    drive_bit(stop_v);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int         fe0;
    int         pe0;
    int         lat;
    logic [7:0] rb;
    logic [7:0] last_good;

    rx_in = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_byte",  rx_byte_out, 8'h00);
    check("rst_valid", rx_byte_valid_out, 1'b0);
    check("rst_fe",    rx_framing_error_out, 1'b0);
    check("rst_pe",    rx_parity_error_out, 1'b0);
    check("rst_busy",  rx_busy_out, 1'b0);
    rst_n = 1'b1;

    // Idle line for 20 cycles
    idle(20);
    check("idle_busy",  rx_busy_out, 1'b0);
    check("idle_byte",  rx_byte_out, 8'h00);
    check("idle_count", obs_q.size(), 0);
    check("idle_fe",    fe_cnt, 0);

    // Single 0x55 frame with latency check
    send_frame(8'h55, 1'b1, 1'b0);
    exp_q.push_back(8'h55);
    idle(8);
    lat = (obs_cyc_q.size() > 0) ? (obs_cyc_q[0] - last_start) : -1;
    check("h55_latency_ok", (lat >= EXP_LAT - 1 && lat <= EXP_LAT + 1), 1'b1);
    expect_bytes("h55");

    // Back-to-back 0x55, 0xaa
    fe0 = fe_cnt;
    send_frame(8'h55, 1'b1, 1'b0);
    send_frame(8'haa, 1'b1, 1'b0);
    exp_q.push_back(8'h55);
    exp_q.push_back(8'haa);
    idle(8);
    check("b2b_spacing_ok",
          (obs_cyc_q.size() == 2) && (obs_cyc_q[1] - obs_cyc_q[0] >= (9 + HAS_PAR) * CPB + 1), 1'b1);
    check("b2b_fe", fe_cnt - fe0, 0);
    expect_bytes("b2b");

    // One-cycle low glitch on an idle line
    fe0 = fe_cnt;
    rx_in = 1'b0;
    @(posedge clk);
    #1;
    idle(2 + HALF + 3);
    check("glitch_busy",  rx_busy_out, 1'b0);
    check("glitch_count", obs_q.size(), 0);
    check("glitch_fe",    fe_cnt - fe0, 0);

    // Randomized frames with random gaps (gap 0 = back-to-back)
    for (int k = 0; k < 16; k++) begin
      rb = 8'($urandom);
      send_frame(rb, 1'b1, 1'b0);
      exp_q.push_back(rb);
      last_good = rb;
      idle($urandom_range(0, 3));
    end
    idle(8);
    expect_bytes("rand");
    check("rand_byte_hold", rx_byte_out, last_good);

    // Framing error followed by a long break
    fe0 = fe_cnt;
    send_frame(8'h3c, 1'b0, 1'b0);
    rx_in = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
    end
    check("brk_fe_once", fe_cnt - fe0, 1);
    check("brk_no_valid", obs_q.size(), 0);
    check("brk_byte_kept", rx_byte_out, last_good);
    check("brk_busy", rx_busy_out, 1'b1);
    idle(10);
    check("brk_recover_busy", rx_busy_out, 1'b0);
    send_frame(8'h81, 1'b1, 1'b0);
    exp_q.push_back(8'h81);
    idle(8);
    expect_bytes("after_brk");

`ifdef UART_RECEIVER_PARITY_EN
    // 0x07 has three ones, so the even-parity bit is 1
    pe0 = pe_cnt;
    send_frame(8'h07, 1'b1, 1'b1);
    idle(8);
    check("par_bad_pe", pe_cnt - pe0, 1);
    check("par_bad_no_valid", obs_q.size(), 0);
    check("par_bad_byte_kept", rx_byte_out, 8'h81);
    pe0 = pe_cnt;
    send_frame(8'h07, 1'b1, 1'b0);
    exp_q.push_back(8'h07);
    idle(8);
    check("par_good_pe", pe_cnt - pe0, 0);
    expect_bytes("par_good");
`endif

    // Reset asserted in the middle of the data bits
    fe0 = fe_cnt;
    pe0 = pe_cnt;
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    drive_bit(1'b1);
    check("mid_busy", rx_busy_out, 1'b1);
    rst_n = 1'b0;
    #2;
    check("mid_rst_byte",  rx_byte_out, 8'h00);
    check("mid_rst_busy",  rx_busy_out, 1'b0);
    check("mid_rst_valid", rx_byte_valid_out, 1'b0);
    rx_in = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(40);
    check("mid_no_valid", obs_q.size(), 0);
    check("mid_no_fe", fe_cnt - fe0, 0);
    check("mid_no_pe", pe_cnt - pe0, 0);
    check("mid_idle_busy", rx_busy_out, 1'b0);

    check("pe_total", pe_cnt, (HAS_PAR != 0) ? 1 : 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Time limit so the run always ends
  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, observed %0d checks, required completion", n_checks);
    $fatal(1, "time limit");
  end

endmodule
